// File: rtl/rv32_pkg.sv
// Shared RV32 fetch definitions: machine width, the canonical NOP,
// the fetch FSM state encoding and the prefetch FIFO entry layout.
package rv32_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction addresses are word aligned; low bits of a target are ignored.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect
// from execute, and the instruction stream handed to decode.
// master = the fetch unit, slave = the surrounding pipeline/memory.
interface fetch_unit_if;
  import rv32_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            de_valid;
  logic            de_ready;
  logic [XLEN-1:0] de_instr;
  logic [XLEN-1:0] de_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect, redirect_pc,
    output de_valid, de_instr, de_pc,
    input  de_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect, redirect_pc,
    input  de_valid, de_instr, de_pc,
    output de_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries between memory and decode.
// Flush empties it in one cycle and overrides any same-cycle push or pop.
// The head entry is read combinationally; there is no write-to-read bypass.
module fetch_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Entry storage: data only, left unreset
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; flush wins over push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, buffers the
// in-order responses in a prefetch FIFO and feeds decode. A redirect
// flushes the FIFO and drops responses still owed to the old stream
// (DRAIN) before fetching from the new target.
// Optional build macro FETCH_PERF_EN adds saturating perf counters
// perf_fetched / perf_flushed.
module fetch_unit
  import rv32_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  fetch_unit_if.master    bus
`ifdef FETCH_PERF_EN
  ,
  output logic [XLEN-1:0] perf_fetched,
  output logic [XLEN-1:0] perf_flushed
`endif
);

  localparam int            CW        = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(DEPTH);

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW-1:0]   discard_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occupancy;
  logic            fifo_full;
  logic            fifo_empty;
  logic            req_fire;
  logic            rsp_keep;
  logic            de_pop;
  logic [XLEN-1:0] rsp_pc;
  fetch_entry_t    fifo_wdata;
  fetch_entry_t    fifo_head;

  // Every queued entry or outstanding request reserves a FIFO slot, so a
  // response can always be accepted without back-pressure on memory.
  assign occupancy          = {1'b0, fifo_count} + {1'b0, outstanding};
  assign bus.imem_req_valid = !rst && (state == FETCH) && !bus.redirect &&
                              (occupancy < DEPTH_LIM);
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // Responses return in order, so the oldest outstanding request's address
  // is fetch_pc minus four per request still in flight.
  assign rsp_pc     = fetch_pc - (XLEN'(outstanding) << 2);
  assign rsp_keep   = bus.imem_rsp_valid && (discard_cnt == '0) && !bus.redirect;
  assign fifo_wdata = '{pc: rsp_pc, instr: bus.imem_rsp_data};

  assign de_pop       = bus.de_valid && bus.de_ready && !bus.redirect;
  assign bus.de_valid = !fifo_empty;
  assign bus.de_instr = fifo_empty ? NOP_INSTR : fifo_head.instr;
  assign bus.de_pc    = fifo_empty ? '0 : fifo_head.pc;

  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_keep),
    .wdata (fifo_wdata),
    .pop   (de_pop),
    .flush (bus.redirect),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .rdata (fifo_head)
  );

  // Fetch FSM: PC sequencing, in-flight tracking and redirect draining
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (bus.redirect) begin
        fetch_pc <= align_pc(bus.redirect_pc);
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      case (state)
        FETCH: begin
          if (bus.redirect) begin
            discard_cnt <= outstanding_nxt;
            state       <= (outstanding_nxt != '0) ? DRAIN : FETCH;
          end
        end
        DRAIN: begin
          // In DRAIN every outstanding request belongs to the old stream,
          // so a further redirect simply keeps counting them down.
          if (bus.imem_rsp_valid) begin
            discard_cnt <= discard_cnt - CW'(1);
            if (discard_cnt == CW'(1)) state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic            rsp_drop;
  logic [XLEN-1:0] flush_amt;

  function automatic logic [XLEN-1:0] sat_add(input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [XLEN:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[XLEN] ? '1 : s[XLEN-1:0];
  endfunction

  assign rsp_drop  = bus.imem_rsp_valid && !rsp_keep;
  assign flush_amt = (bus.redirect ? XLEN'(fifo_count) : '0) + XLEN'(rsp_drop);

  // Saturating counts of FIFO writes and of flushed or dropped instructions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= sat_add(perf_fetched, XLEN'(rsp_keep));
      perf_flushed <= sat_add(perf_flushed, flush_amt);
    end
  end
`endif

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory with configurable latency, a
// stream-level reference (expected next request / next delivered PC,
// responses owed to a flushed stream), directed scenarios then random traffic.
module tb_fetch_unit;
  import rv32_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] mq_addr [$];
  int          mq_due  [$];
  int          lat_lo = 1, lat_hi = 1, rsp_pct = 100;
  bit          hold = 0, rand_mode = 0;

  logic [31:0] exp_req, exp_de, prev_addr;
  bit          prev_stall = 0;
  int          drop_left = 0;
  int          n_xfer = 0, n_pop = 0, n_drop = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: sample/check at negedge, then update memory and reference.
  task automatic tick();
    logic xfer, rsp, redir, pop;
    logic [31:0] tgt, addr;
    int scyc;
    @(negedge clk);
    scyc = cyc;
    xfer = 0; rsp = 0; redir = 0; pop = 0;
    addr = bus.imem_req_addr;
    tgt  = bus.redirect_pc;
    if (!rst) begin
      xfer  = bus.imem_req_valid && bus.imem_req_ready;
      rsp   = bus.imem_rsp_valid;
      redir = bus.redirect;
      pop   = bus.de_valid && bus.de_ready && !redir;
      if (prev_stall && bus.imem_req_valid) check("req_addr_hold", addr, prev_addr);
      if (redir || drop_left > 0) check("no_req_in_drain", bus.imem_req_valid, 1'b0);
      if (xfer) begin
        check("req_addr", addr, exp_req);
        exp_req = exp_req + 32'd4;
        n_xfer++;
      end
      if (pop) begin
        check("de_pc", bus.de_pc, exp_de);
        check("de_instr", bus.de_instr, mem_word(exp_de));
        exp_de = exp_de + 32'd4;
        n_pop++;
      end
      if (!bus.de_valid) begin
        check("idle_instr", bus.de_instr, NOP_INSTR);
        check("idle_pc", bus.de_pc, 32'h0);
      end
      if (rsp && !redir && drop_left > 0) begin
        drop_left--;
        n_drop++;
      end
      prev_stall = bus.imem_req_valid && !bus.imem_req_ready;
      prev_addr  = addr;
    end else begin
      prev_stall = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (xfer) begin
      mq_addr.push_back(addr);
      mq_due.push_back(scyc + $urandom_range(lat_hi, lat_lo));
    end
    if (rsp && mq_addr.size() > 0) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (redir) begin
      drop_left = mq_addr.size();
      exp_req   = {tgt[31:2], 2'b00};
      exp_de    = exp_req;
    end
    if (rand_mode && !rst) begin
      bus.imem_req_ready = ($urandom_range(99, 0) < 75);
      bus.de_ready       = ($urandom_range(99, 0) < 70);
      bus.redirect       = ($urandom_range(99, 0) < 4);
      bus.redirect_pc    = $urandom;
    end
    if (!rst && !hold && mq_addr.size() > 0 && mq_due[0] <= cyc &&
        $urandom_range(99, 0) < rsp_pct) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mq_addr[0]);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect       = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.de_ready       = 1'b1;
    mq_addr.delete();
    mq_due.delete();
    tick();
    tick();
    check("rst_req_valid", bus.imem_req_valid, 1'b0);
    check("rst_req_addr", bus.imem_req_addr, RESET_PC);
    check("rst_de_valid", bus.de_valid, 1'b0);
    check("rst_de_instr", bus.de_instr, NOP_INSTR);
    check("rst_de_pc", bus.de_pc, 32'h0);
    rst        = 1'b0;
    exp_req    = RESET_PC;
    exp_de     = RESET_PC;
    drop_left  = 0;
    prev_stall = 0;
  endtask

  initial begin
    logic [31:0] a0;
    logic [31:0] wa [3];
    int n0, p0, d0, na;
    bit found;

    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect       = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.de_ready       = 1'b0;

    // Reset, then minimum-latency memory with decode always ready
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      #2;
      check("r026_req_valid", bus.imem_req_valid, 1'b1);
      check("r026_req_addr", bus.imem_req_addr, 32'(4 * (k - 1)));
      check("r026_de_valid", bus.de_valid, (k >= 3) ? 1'b1 : 1'b0);
      if (k >= 3) check("r026_de_pc", bus.de_pc, 32'(4 * (k - 3)));
      tick();
    end

    // Decode stalled: FIFO fills, issue stops at DEPTH requests
    bus.de_ready    = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    tick();
    bus.redirect = 1'b0;
    n0 = n_xfer;
    repeat (20) tick();
    #2;
    check("r027_req_count", 32'(n_xfer - n0), 32'(DEPTH));
    check("r027_req_stopped", bus.imem_req_valid, 1'b0);
    check("r027_head_valid", bus.de_valid, 1'b1);
    check("r027_head_pc", bus.de_pc, 32'h0000_0200);
    bus.de_ready = 1'b1;
    p0 = n_pop;
    repeat (20) tick();
    check("r027_resume", ((n_pop - p0) >= 8) ? 1'b1 : 1'b0, 1'b1);

    // Redirect together with a response and a pop
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0300;
    #2;
    check("r029_no_req", bus.imem_req_valid, 1'b0);
    tick();
    bus.redirect = 1'b0;
    #2;
    check("r029_flushed", bus.de_valid, 1'b0);
    check("r029_req_valid", bus.imem_req_valid, 1'b1);
    check("r029_req_addr", bus.imem_req_addr, 32'h0000_0300);
    repeat (10) tick();

    // Three requests in flight, then redirect to an unaligned target
    hold = 1;
    bus.imem_rsp_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mq_addr.size() >= 3) break;
      tick();
    end
    check("r028_in_flight", 32'(mq_addr.size()), 32'd3);
    bus.imem_req_ready = 1'b0;
    bus.redirect       = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    #2;
    check("r028_no_req", bus.imem_req_valid, 1'b0);
    tick();
    bus.redirect       = 1'b0;
    bus.imem_req_ready = 1'b1;
    hold = 0;
    d0 = n_drop;
    #2;
    check("r028_fifo_empty", bus.de_valid, 1'b0);
    check("r028_drain_no_req", bus.imem_req_valid, 1'b0);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      #2;
      if (bus.imem_req_valid) begin
        found = 1;
        break;
      end
    end
    check("r028_resumed", found, 1'b1);
    check("r028_next_addr", bus.imem_req_addr, 32'h0000_0100);
    check("r028_dropped", 32'(n_drop - d0), 32'd3);
    tick();
    p0 = n_pop;
    repeat (10) tick();
    check("r028_delivered", ((n_pop - p0) > 0) ? 1'b1 : 1'b0, 1'b1);

    // Memory not ready for 5 cycles: request address must hold
    bus.imem_req_ready = 1'b0;
    #2;
    a0 = bus.imem_req_addr;
    check("r030_stall_valid", bus.imem_req_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      #2;
      check("r030_stall_addr", bus.imem_req_addr, a0);
    end
    bus.imem_req_ready = 1'b1;
    repeat (4) tick();

    // Address wrap at the top of the space
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    tick();
    bus.redirect = 1'b0;
    na = 0;
    for (int i = 0; i < 20; i++) begin
      if (na >= 3) break;
      #2;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        wa[na] = bus.imem_req_addr;
        na++;
      end
      tick();
    end
    check("r030_wrap_count", 32'(na), 32'd3);
    check("r030_wrap_a0", wa[0], 32'hFFFF_FFF8);
    check("r030_wrap_a1", wa[1], 32'hFFFF_FFFC);
    check("r030_wrap_a2", wa[2], 32'h0000_0000);
    repeat (10) tick();

    // Random traffic, a reset in mid-operation, more random traffic
    lat_lo = 1; lat_hi = 4; rsp_pct = 70; rand_mode = 1;
    repeat (1500) tick();
    do_reset();
    #2;
    check("midrst_first_valid", bus.imem_req_valid, 1'b1);
    check("midrst_first_addr", bus.imem_req_addr, RESET_PC);
    p0 = n_pop;
    repeat (1500) tick();
    rand_mode = 0;
    bus.redirect       = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.de_ready       = 1'b1;
    repeat (30) tick();
    check("random_progress", ((n_pop - p0) > 200) ? 1'b1 : 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
